// File: rtl/sum_seq.sv
// Multi-cycle adder/subtractor: sums WIDTH-bit operands CHUNK bits per clock, LSB slice first.
// Registered result, carry-out and signed overflow; start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | summing one CHUNK slice per clock
// DONE  | results updated, done pulse; start here re-enters RUN directly
module sum_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);
    localparam int NSLICE = WIDTH / CHUNK;
    localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK:0]         slice;
    logic                   c_msb;
    logic [WIDTH+CHUNK-1:0] acc_wide;
    logic [WIDTH+CHUNK-1:0] opa_wide;
    logic [WIDTH+CHUNK-1:0] opb_wide;

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        slice    = {1'b0, opa_q[CHUNK-1:0]} + {1'b0, opb_q[CHUNK-1:0]}
                 + {{CHUNK{1'b0}}, carry_q};
        // Carry into the slice MSB recovered from the sum bit; on the final slice this is the carry into bit WIDTH-1.
        c_msb    = slice[CHUNK-1] ^ opa_q[CHUNK-1] ^ opb_q[CHUNK-1];
        acc_wide = {slice[CHUNK-1:0], acc_q};
        opa_wide = {{CHUNK{1'b0}}, opa_q};
        opb_wide = {{CHUNK{1'b0}}, opb_q};

        case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                opa_d   = opa_wide[WIDTH+CHUNK-1:CHUNK];
                opb_d   = opb_wide[WIDTH+CHUNK-1:CHUNK];
                acc_d   = acc_wide[WIDTH+CHUNK-1:CHUNK];
                carry_d = slice[CHUNK];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    s_d     = acc_wide[WIDTH+CHUNK-1:CHUNK];
                    cout_d  = slice[CHUNK];
                    ovf_d   = c_msb ^ slice[CHUNK];
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = start ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_q != RUN && start) begin
            opa_d   = a;
            opb_d   = sub ? ~b : b;
            carry_d = sub;
            cnt_d   = '0;
            acc_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign s    = s_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
endmodule

// File: tb/tb_sum_seq.sv
// Scoreboard bench for sum_seq: directed 16/4 vectors plus 8-bit instances with CHUNK 1, 2 and 8.
module tb_sum_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int sweep_fin = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    logic        reset, reset8;
    logic        start, sub, busy, done, cout, ovf;
    logic [15:0] a, b, s;

    sum_seq #(.WIDTH(16), .CHUNK(4)) u_dut (
        .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .s(s), .cout(cout), .ovf(ovf)
    );

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
        int          dcyc;
    } exp16_t;
    exp16_t q16[$];

    always @(negedge clk) begin
        if (done) begin
            chk("busy_in_done", {31'd0, busy}, 32'd0);
            if (q16.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=done required=no_done cyc=%0d", cyc);
            end else begin
                exp16_t e;
                e = q16.pop_front();
                chk("s16", {16'd0, s}, {16'd0, e.s});
                chk("cout16", {31'd0, cout}, {31'd0, e.c});
                chk("ovf16", {31'd0, ovf}, {31'd0, e.o});
                chk("latency16", cyc, e.dcyc);
            end
        end
    end

    task automatic op16(input logic [15:0] ta, input logic [15:0] tb_, input logic ts,
                        input logic [15:0] es, input logic ec, input logic eo);
        int n;
        exp16_t e;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            failures++;
            $display("FAIL op16_wait_idle actual=busy required=idle");
        end
        a = ta; b = tb_; sub = ts; start = 1'b1;
        e.s = es; e.c = ec; e.o = eo; e.dcyc = cyc + 1 + 4;
        q16.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain16();
        int n;
        n = 0;
        while ((q16.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q16.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain16_timeout actual=%0d required=0", q16.size());
        end
        @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_s"}, {16'd0, s}, 32'd0);
        chk({tag, "_cout"}, {31'd0, cout}, 32'd0);
        chk({tag, "_ovf"}, {31'd0, ovf}, 32'd0);
    endtask

    initial begin
        exp16_t e;
        int n;
        reset = 1'b1; reset8 = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        reset = 1'b0; reset8 = 1'b0;
        @(negedge clk);

        op16(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        drain16();

        op16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        op16(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        op16(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        op16(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        op16(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        op16(16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 1'b0);
        drain16();

        // start held high with operands churning during RUN, then a back-to-back op from the done cycle
        a = 16'h1234; b = 16'h4321; sub = 1'b0; start = 1'b1;
        e.s = 16'h5555; e.c = 1'b0; e.o = 1'b0; e.dcyc = cyc + 1 + 4;
        q16.push_back(e);
        repeat (4) begin
            @(negedge clk);
            a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
        end
        @(negedge clk);
        chk("done_cycle_seen", {31'd0, done}, 32'd1);
        a = 16'h9000; b = 16'h1000; sub = 1'b1;
        e.s = 16'h8000; e.c = 1'b1; e.o = 1'b0; e.dcyc = cyc + 1 + 4;
        q16.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        drain16();

        // reset in the second RUN cycle aborts; no done may follow
        a = 16'h0F0F; b = 16'h0101; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_zero("abort");
        reset = 1'b0;
        repeat (10) @(negedge clk);
        op16(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);
        drain16();

        n = 0;
        while (sweep_fin < 3 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (sweep_fin < 3) begin
            checks++;
            failures++;
            $display("FAIL sweep_timeout actual=%0d required=3", sweep_fin);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    function automatic logic [9:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic m);
        logic [7:0] yy;
        logic [8:0] t;
        logic       o;
        yy = m ? ~y : y;
        t = {1'b0, x} + {1'b0, yy} + {8'd0, m};
        o = (x[7] == yy[7]) && (t[7] != x[7]);
        return {o, t[8], t[7:0]};
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
        localparam int CH = (gi == 0) ? 1 : (gi == 1) ? 2 : 8;
        localparam int NS = 8 / CH;

        logic       st, sb, bz, dn, co, ov;
        logic [7:0] aa, bb, ss;
        logic [9:0] qe[$];
        int         qc[$];

        sum_seq #(.WIDTH(8), .CHUNK(CH)) u_dut8 (
            .clk(clk), .reset(reset8), .start(st), .sub(sb), .a(aa), .b(bb),
            .busy(bz), .done(dn), .s(ss), .cout(co), .ovf(ov)
        );

        always @(negedge clk) begin
            if (dn) begin
                if (qe.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done8 chunk=%0d actual=done required=no_done", CH);
                end else begin
                    logic [9:0] ev;
                    int         ec;
                    ev = qe.pop_front();
                    ec = qc.pop_front();
                    chk($sformatf("res8_c%0d", CH), {22'd0, ov, co, ss}, {22'd0, ev});
                    chk($sformatf("latency8_c%0d", CH), cyc, ec);
                    chk($sformatf("busy_in_done8_c%0d", CH), {31'd0, bz}, 32'd0);
                end
            end
        end

        task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic m);
            int n;
            n = 0;
            while (bz && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (bz) begin
                checks++;
                failures++;
                $display("FAIL op8_wait_idle chunk=%0d actual=busy required=idle", CH);
            end
            aa = x; bb = y; sb = m; st = 1'b1;
            qe.push_back(ref8(x, y, m));
            qc.push_back(cyc + 1 + NS);
            @(negedge clk);
            st = 1'b0;
        endtask

        initial begin
            logic [7:0] corners[4];
            int n;
            corners[0] = 8'h00; corners[1] = 8'hFF; corners[2] = 8'h7F; corners[3] = 8'h80;
            st = 1'b0; sb = 1'b0; aa = '0; bb = '0;
            repeat (6) @(negedge clk);
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    for (int m = 0; m < 2; m++)
                        op8(corners[i], corners[j], 1'(m));
            for (int k = 0; k < 8; k++)
                op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'(k));
            n = 0;
            while ((qe.size() != 0 || bz) && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (qe.size() != 0) begin
                checks++;
                failures++;
                $display("FAIL drain8_timeout chunk=%0d actual=%0d required=0", CH, qe.size());
            end
            sweep_fin++;
        end
    end
endmodule
